// File: rtl/clk_rst_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : clk_rst_pkg
// Description : Shared types and constants for the reset sequencer and
//               clock-enable generator (state encoding, lock-loss counter
//               sizing, default parameter values).
// Revision    : 1.0 - initial release
// ============================================================================
package clk_rst_pkg;

    // Sequencer state encoding
    typedef logic [2:0] state_t;
    localparam state_t WAIT_LOCK = 3'd0;
    localparam state_t DEBOUNCE  = 3'd1;
    localparam state_t RELEASE   = 3'd2;
    localparam state_t RUN       = 3'd3;
    localparam state_t HOLD      = 3'd4;

    // Lock-loss event counter
    localparam int                    LOSS_CNT_W   = 8;
    localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = '1;

    // Default parameter values
    localparam int DEF_NUM_DOMAINS    = 4;
    localparam int DEF_STAGGER_CYCLES = 16;
    localparam int DEF_LOCK_DEBOUNCE  = 256;
    localparam int DEF_SOFT_HOLD      = 32;
    localparam int DEF_NUM_CE         = 2;
    localparam int DEF_CE_DIV_W       = 16;

    // Increment that sticks at the maximum instead of wrapping
    function automatic logic [LOSS_CNT_W-1:0] sat_inc_loss(input logic [LOSS_CNT_W-1:0] v);
        return (v == LOSS_CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage : clk_rst_pkg
`default_nettype wire

// File: rtl/ce_div_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ce_div_gen
// Description : One programmable clock-enable channel. Emits a one-cycle
//               strobe on the first cycle that run is high, then every N
//               cycles, where N = div (0 treated as 1). N is re-sampled
//               only when the period wraps.
// Revision    : 1.0 - initial release
// Ports       : clk_100m - system clock
//               rst_n    - asynchronous active-low reset
//               run      - high for every cycle the channel should be active
//                          (already aligned to the cycle the strobe appears)
//               div      - divide ratio
//               strobe   - registered one-cycle enable pulse
// ============================================================================
module ce_div_gen
    import clk_rst_pkg::*;
#(
    parameter int DIV_W = DEF_CE_DIV_W
) (
    input  logic             clk_100m,
    input  logic             rst_n,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             strobe
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_period;
    logic             r_strobe;
    logic [DIV_W-1:0] w_div_eff;

    assign w_div_eff = (div == '0) ? DIV_W'(1) : div;

    // r_cnt is the position inside the current period; position 0 is the
    // strobe cycle and also the only point where a new ratio is latched.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_period <= DIV_W'(1);
            r_strobe <= 1'b0;
        end else if (!run) begin
            r_cnt    <= '0;
            r_period <= DIV_W'(1);
            r_strobe <= 1'b0;
        end else if (r_cnt == '0) begin
            r_strobe <= 1'b1;
            r_period <= w_div_eff;
            r_cnt    <= (w_div_eff == DIV_W'(1)) ? '0 : DIV_W'(1);
        end else begin
            r_strobe <= 1'b0;
            r_cnt    <= (r_cnt == r_period - DIV_W'(1)) ? '0 : r_cnt + DIV_W'(1);
        end
    end

    assign strobe = r_strobe;

endmodule : ce_div_gen
`default_nettype wire

// File: rtl/clk_rst_mgr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : clk_rst_mgr
// Description : Reset sequencer and clock-enable generator. Qualifies the
//               MMCM lock, releases NUM_DOMAINS resets in staggered order,
//               re-sequences on lock loss or software request and drives
//               NUM_CE programmable clock-enable strobes.
// Revision    : 1.0 - initial release
// Ports       : clk_100m      - system clock (only clock)
//               rst_n         - asynchronous active-low reset
//               mmcm_locked   - asynchronous MMCM lock indication
//               soft_rst_req  - single-cycle software reset request
//               lock_lost_clr - clears the sticky lock_lost flag
//               ce_div        - per-channel divide ratios, packed
//               domain_rst_n  - active-low sequenced domain resets
//               ce_strobe     - one-cycle clock-enable pulses
//               all_ready     - high while in RUN
//               lock_lost     - sticky lock-loss flag
//               lock_loss_cnt - saturating lock-loss event counter
// ============================================================================
module clk_rst_mgr
    import clk_rst_pkg::*;
#(
    parameter int NUM_DOMAINS    = DEF_NUM_DOMAINS,
    parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES,
    parameter int LOCK_DEBOUNCE  = DEF_LOCK_DEBOUNCE,
    parameter int SOFT_HOLD      = DEF_SOFT_HOLD,
    parameter int NUM_CE         = DEF_NUM_CE,
    parameter int CE_DIV_W       = DEF_CE_DIV_W
) (
    input  logic                         clk_100m,
    input  logic                         rst_n,
    input  logic                         mmcm_locked,
    input  logic                         soft_rst_req,
    input  logic                         lock_lost_clr,
    input  logic [NUM_CE*CE_DIV_W-1:0]   ce_div,
    output logic [NUM_DOMAINS-1:0]       domain_rst_n,
    output logic [NUM_CE-1:0]            ce_strobe,
    output logic                         all_ready,
    output logic                         lock_lost,
    output logic [LOSS_CNT_W-1:0]        lock_loss_cnt
);

    localparam int DEB_W  = $clog2(LOCK_DEBOUNCE) + 1;
    localparam int STG_W  = $clog2(STAGGER_CYCLES) + 1;
    localparam int HOLD_W = $clog2(SOFT_HOLD) + 1;
    localparam int IDX_W  = $clog2(NUM_DOMAINS) + 1;

    // Lock synchroniser
    logic r_sync1;
    logic r_sync2;
    logic w_locked_s;

    // Sequencer state and counters
    state_t                  r_state,     w_state_next;
    logic [DEB_W-1:0]        r_deb_cnt,   w_deb_next;
    logic [STG_W-1:0]        r_stg_cnt,   w_stg_next;
    logic [HOLD_W-1:0]       r_hold_cnt,  w_hold_next;
    logic [IDX_W-1:0]        r_idx,       w_idx_next;

    // Registered outputs
    logic [NUM_DOMAINS-1:0]  r_dom_rst_n, w_dom_next;
    logic                    r_all_ready;
    logic                    r_lock_lost, w_lost_next;
    logic [LOSS_CNT_W-1:0]   r_loss_cnt,  w_loss_cnt_next;
    logic                    w_run_next;

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= mmcm_locked;
            r_sync2 <= r_sync1;
        end
    end

    assign w_locked_s = r_sync2;

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= WAIT_LOCK;
            r_deb_cnt   <= '0;
            r_stg_cnt   <= '0;
            r_hold_cnt  <= '0;
            r_idx       <= '0;
            r_dom_rst_n <= '0;
            r_all_ready <= 1'b0;
            r_lock_lost <= 1'b0;
            r_loss_cnt  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_deb_cnt   <= w_deb_next;
            r_stg_cnt   <= w_stg_next;
            r_hold_cnt  <= w_hold_next;
            r_idx       <= w_idx_next;
            r_dom_rst_n <= w_dom_next;
            r_all_ready <= w_run_next;
            r_lock_lost <= w_lost_next;
            r_loss_cnt  <= w_loss_cnt_next;
        end
    end

    // Next-state logic. Output registers are loaded from the same decision so
    // that every output changes on the edge the state changes.
    always_comb begin
        w_state_next    = r_state;
        w_deb_next      = r_deb_cnt;
        w_stg_next      = r_stg_cnt;
        w_hold_next     = r_hold_cnt;
        w_idx_next      = r_idx;
        w_dom_next      = r_dom_rst_n;
        w_lost_next     = r_lock_lost & ~lock_lost_clr;
        w_loss_cnt_next = r_loss_cnt;

        case (r_state)
            WAIT_LOCK: begin
                w_dom_next = '0;
                if (w_locked_s) begin
                    w_state_next = DEBOUNCE;
                    w_deb_next   = '0;
                end
            end

            DEBOUNCE: begin
                w_dom_next = '0;
                if (!w_locked_s) begin
                    // Lock never qualified, so this is not a loss event
                    w_state_next = WAIT_LOCK;
                end else if (w_deb_next == DEB_W'(LOCK_DEBOUNCE - 1)) begin
                    w_state_next = RELEASE;
                    w_dom_next   = NUM_DOMAINS'(1);
                    w_idx_next   = IDX_W'(1);
                    w_stg_next   = '0;
                end else begin
                    w_deb_next = r_deb_cnt + DEB_W'(1);
                end
            end

            RELEASE, RUN: begin
                if (!w_locked_s) begin
                    // Lock loss takes priority over a coincident soft request
                    w_state_next    = WAIT_LOCK;
                    w_dom_next      = '0;
                    w_lost_next     = 1'b1;
                    w_loss_cnt_next = sat_inc_loss(r_loss_cnt);
                end else if (soft_rst_req) begin
                    w_state_next = HOLD;
                    w_dom_next   = '0;
                    w_hold_next  = '0;
                end else if (r_state == RELEASE) begin
                    if (r_idx == IDX_W'(NUM_DOMAINS)) begin
                        w_state_next = RUN;
                    end else if (r_stg_cnt == STG_W'(STAGGER_CYCLES - 1)) begin
                        for (int k = 0; k < NUM_DOMAINS; k++) begin
                            w_dom_next[k] = r_dom_rst_n[k] | (IDX_W'(k) == r_idx);
                        end
                        w_idx_next = r_idx + IDX_W'(1);
                        w_stg_next = '0;
                    end else begin
                        w_stg_next = r_stg_cnt + STG_W'(1);
                    end
                end
            end

            HOLD: begin
                // Runs to completion regardless of lock; DEBOUNCE re-checks it
                w_dom_next = '0;
                if (r_hold_cnt == HOLD_W'(SOFT_HOLD - 1)) begin
                    w_state_next = DEBOUNCE;
                    w_deb_next   = '0;
                end else begin
                    w_hold_next = r_hold_cnt + HOLD_W'(1);
                end
            end

            default: begin
                w_state_next = WAIT_LOCK;
                w_dom_next   = '0;
            end
        endcase
    end

    // CE channels see the upcoming state so their first strobe lines up with
    // the edge that raises all_ready.
    assign w_run_next = (w_state_next == RUN);

    for (genvar i = 0; i < NUM_CE; i++) begin : g_ce
        ce_div_gen #(
            .DIV_W (CE_DIV_W)
        ) u_ce_div_gen (
            .clk_100m (clk_100m),
            .rst_n    (rst_n),
            .run      (w_run_next),
            .div      (ce_div[i*CE_DIV_W +: CE_DIV_W]),
            .strobe   (ce_strobe[i])
        );
    end

    assign domain_rst_n  = r_dom_rst_n;
    assign all_ready     = r_all_ready;
    assign lock_lost     = r_lock_lost;
    assign lock_loss_cnt = r_loss_cnt;

endmodule : clk_rst_mgr
`default_nettype wire
